// File: rtl/bcd_updown_counter_if.sv
// Bus bundle for bcd_updown_counter: control, load data, count and carry-out.
interface bcd_updown_counter_if #(
    parameter int DIGITS = 2
);
    logic                en;
    logic                ci;
    logic                up;
    logic                ld;
    logic [4*DIGITS-1:0] d;
    logic [4*DIGITS-1:0] q;
    logic                co;

    modport master (
        output en, ci, up, ld, d,
        input  q, co
    );

    modport slave (
        input  en, ci, up, ld, d,
        output q, co
    );
endinterface

// File: rtl/bcd_updown_counter.sv
// Multi-digit up/down BCD counter with top-digit modulus, load and carry chain.
// Define BCD_UPDOWN_COUNTER_SAT_EN for saturating instead of wrapping ends.
module bcd_updown_counter #(
    parameter int DIGITS  = 2,
    parameter int TOP_MOD = 10
) (
    input logic                  clk,
    input logic                  mr_n,
    bcd_updown_counter_if.slave  bus
);
    localparam logic [3:0] TOP_MAX = 4'(TOP_MOD - 1);

    logic [4*DIGITS-1:0] q_r;
    logic [4*DIGITS-1:0] q_next;
    logic [4*DIGITS-1:0] ld_val;
    logic [3:0]          dig;
    logic [3:0]          ldig;
    logic                low_max;
    logic                low_zero;
    logic                terminal;

    function automatic logic [3:0] max_of(input int k);
        return (k == DIGITS - 1) ? TOP_MAX : 4'd9;
    endfunction

    // A digit steps only when every lower digit sits at its rollover value.
    always_comb begin
        q_next   = q_r;
        low_max  = 1'b1;
        low_zero = 1'b1;
        dig      = '0;
        for (int k = 0; k < DIGITS; k++) begin
            dig = q_r[4*k +: 4];
            if (bus.up) begin
                if (low_max)
                    q_next[4*k +: 4] = (dig == max_of(k)) ? 4'd0 : dig + 4'd1;
            end else begin
                if (low_zero)
                    q_next[4*k +: 4] = (dig == 4'd0) ? max_of(k) : dig - 4'd1;
            end
            low_max  = low_max & (dig == max_of(k));
            low_zero = low_zero & (dig == 4'd0);
        end
        terminal = bus.up ? low_max : low_zero;
`ifdef BCD_UPDOWN_COUNTER_SAT_EN
        if (terminal)
            q_next = q_r;
`endif
    end

    always_comb begin
        ld_val = '0;
        ldig   = '0;
        for (int k = 0; k < DIGITS; k++) begin
            ldig = bus.d[4*k +: 4];
            ld_val[4*k +: 4] = (ldig > max_of(k)) ? 4'd0 : ldig;
        end
    end

    always_ff @(posedge clk or negedge mr_n) begin
        if (!mr_n)
            q_r <= '0;
        else if (bus.ld)
            q_r <= ld_val;
        else if (bus.en && bus.ci)
            q_r <= q_next;
    end

    assign bus.q  = q_r;
    assign bus.co = mr_n & bus.en & bus.ci & ~bus.ld & terminal;
endmodule

// File: tb/tb_bcd_updown_counter.sv
// Bench for bcd_updown_counter: integer reference model plus directed checks.
module tb_bcd_updown_counter;
    logic       clk = 1'b0;
    logic       mr_n;
    logic       en, ci, up, ld;
    logic [7:0] d;
    logic       c_en, c_up, c_ld;
    logic [3:0] c_dl;
    logic [7:0] c_du;

    int checks = 0;
    int errors = 0;
    int n  = 0;
    int cn = 0;

    always #5 clk = ~clk;

    bcd_updown_counter_if #(.DIGITS(2)) mif ();
    bcd_updown_counter_if #(.DIGITS(1)) cl ();
    bcd_updown_counter_if #(.DIGITS(2)) cu ();

    assign mif.en = en;
    assign mif.ci = ci;
    assign mif.up = up;
    assign mif.ld = ld;
    assign mif.d  = d;

    assign cl.en = c_en;
    assign cl.ci = 1'b1;
    assign cl.up = c_up;
    assign cl.ld = c_ld;
    assign cl.d  = c_dl;
    assign cu.en = c_en;
    assign cu.ci = cl.co;
    assign cu.up = c_up;
    assign cu.ld = c_ld;
    assign cu.d  = c_du;

    bcd_updown_counter #(.DIGITS(2), .TOP_MOD(6)) dut (
        .clk(clk), .mr_n(mr_n), .bus(mif)
    );
    bcd_updown_counter #(.DIGITS(1), .TOP_MOD(10)) lower (
        .clk(clk), .mr_n(mr_n), .bus(cl)
    );
    bcd_updown_counter #(.DIGITS(2), .TOP_MOD(6)) upper (
        .clk(clk), .mr_n(mr_n), .bus(cu)
    );

    function automatic logic [7:0] bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int clamp60(input logic [7:0] dv);
        int hi, lo;
        hi = int'(dv[7:4]);
        lo = int'(dv[3:0]);
        if (lo > 9) lo = 0;
        if (hi >= 6) hi = 0;
        return hi * 10 + lo;
    endfunction

    function automatic int step(input int v, input logic dir, input int m, input bit sat);
        if (sat && dir && v == m - 1) return v;
        if (sat && !dir && v == 0) return v;
        return dir ? (v + 1) % m : (v + m - 1) % m;
    endfunction

`ifdef BCD_UPDOWN_COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk or negedge mr_n) begin
        if (!mr_n) begin
            n  = 0;
            cn = 0;
        end else begin
            if (ld) n = clamp60(d);
            else if (en && ci) n = step(n, up, 60, SAT);
            if (c_ld) cn = clamp60(c_du) * 10 + ((c_dl > 4'd9) ? 0 : int'(c_dl));
            else if (c_en) cn = step(cn, c_up, 600, 1'b0);
        end
    end

    always @(negedge clk) begin
        check("model_q", {24'd0, mif.q}, {24'd0, bcd2(n)});
        check("model_co", {31'd0, mif.co},
              {31'd0, mr_n & en & ci & ~ld & (up ? (n == 59) : (n == 0))});
`ifndef BCD_UPDOWN_COUNTER_SAT_EN
        check("chain_lo", {28'd0, cl.q}, 32'(cn % 10));
        check("chain_hi", {24'd0, cu.q}, {24'd0, bcd2(cn / 10)});
        check("chain_co", {31'd0, cu.co},
              {31'd0, mr_n & c_en & ~c_ld & (c_up ? (cn == 599) : (cn == 0))});
`endif
    end

    task automatic tick(input int k = 1);
        repeat (k) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        mr_n = 1'b0; en = 1'b0; ci = 1'b1; up = 1'b1; ld = 1'b0; d = '0;
        c_en = 1'b0; c_up = 1'b1; c_ld = 1'b0; c_dl = '0; c_du = '0;
        #3;
        check("reset_q", {24'd0, mif.q}, 32'h00);
        check("reset_co", {31'd0, mif.co}, 32'd0);
        tick(2);
        mr_n = 1'b1;
        en   = 1'b1;
        tick(37);
        check("up_to_37", {24'd0, mif.q}, 32'h37);
        mr_n = 1'b0;
        #1;
        check("mid_reset_q", {24'd0, mif.q}, 32'h00);
        check("mid_reset_co", {31'd0, mif.co}, 32'd0);
        #1;
        mr_n = 1'b1;
        tick();
        check("after_release", {24'd0, mif.q}, 32'h01);

        ld = 1'b1; d = 8'h00;
        tick();
        ld = 1'b0;
        tick(59);
        check("reach_59", {24'd0, mif.q}, 32'h59);
        check("co_at_59", {31'd0, mif.co}, 32'd1);
        tick();
`ifdef BCD_UPDOWN_COUNTER_SAT_EN
        check("sat_hold_59", {24'd0, mif.q}, 32'h59);
        tick(2);
        check("sat_still_59", {24'd0, mif.q}, 32'h59);
        check("sat_co_hi", {31'd0, mif.co}, 32'd1);
`else
        check("wrap_00", {24'd0, mif.q}, 32'h00);
        check("co_after_wrap", {31'd0, mif.co}, 32'd0);
`endif

        ld = 1'b1; d = 8'h10;
        tick();
        ld = 1'b0; up = 1'b0;
        tick();
        check("down_09", {24'd0, mif.q}, 32'h09);
        tick(2);
        check("down_07", {24'd0, mif.q}, 32'h07);
        up = 1'b1;
        tick();
        check("up_08", {24'd0, mif.q}, 32'h08);
        ld = 1'b1; d = 8'h00;
        tick();
        ld = 1'b0; up = 1'b0;
        #1;
        check("co_down_00", {31'd0, mif.co}, 32'd1);
        tick();
`ifdef BCD_UPDOWN_COUNTER_SAT_EN
        check("sat_hold_00", {24'd0, mif.q}, 32'h00);
        tick(2);
        check("sat_still_00", {24'd0, mif.q}, 32'h00);
`else
        check("down_wrap_59", {24'd0, mif.q}, 32'h59);
`endif

        ld = 1'b1; d = 8'h47;
        #1;
        check("ld_co_low", {31'd0, mif.co}, 32'd0);
        tick();
        check("load_47", {24'd0, mif.q}, 32'h47);
        d = 8'h7A;
        tick();
        check("load_clamp", {24'd0, mif.q}, 32'h00);
        d = 8'h23;
        tick();
        ld = 1'b0; ci = 1'b0;
        tick(5);
        check("ci_gate_q", {24'd0, mif.q}, 32'h23);
        check("ci_gate_co", {31'd0, mif.co}, 32'd0);
        ci = 1'b1;

`ifndef BCD_UPDOWN_COUNTER_SAT_EN
        c_ld = 1'b1; c_dl = 4'd7; c_du = 8'h12;
        tick();
        c_ld = 1'b0; c_en = 1'b1;
        tick(3);
        check("chain_130_lo", {28'd0, cl.q}, 32'd0);
        check("chain_130_hi", {24'd0, cu.q}, 32'h13);
        c_up = 1'b0;
        tick();
        check("chain_129_lo", {28'd0, cl.q}, 32'd9);
        check("chain_129_hi", {24'd0, cu.q}, 32'h12);
        c_ld = 1'b1; c_dl = 4'd9; c_du = 8'h59; c_up = 1'b1;
        tick();
        c_ld = 1'b0;
        #1;
        check("chain_co_599", {31'd0, cu.co}, 32'd1);
        tick();
        check("chain_wrap_lo", {28'd0, cl.q}, 32'd0);
        check("chain_wrap_hi", {24'd0, cu.q}, 32'h00);
`endif
        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
- Parametrised multi-digit BCD counter: the next-generation successor to the single-digit decade counter.
- Adds these over the single-digit block: N cascaded digits, a configurable modulus on the top digit (e.g. 60 for clock minutes), up/down counting, synchronous parallel load, and a carry-in for chaining instances.
- Sits in the display/timekeeping path; drives 7-seg decoders and cascades to further counters via co.

Parameters:
- DIGITS, 2, number of BCD digits (1..8); digit 0 is least significant.
- TOP_MOD, 10, modulus of the most significant digit (2..10); total modulus = 10^(DIGITS-1) * TOP_MOD.

Ports:
- clk  input  1  rising-edge clock.
- mr_n  input  1  asynchronous active-low master reset.
- en  input  1  count enable.
- ci  input  1  carry-in from a lower-order counter; tie to 1 when unused.
- up  input  1  direction: 1 = count up, 0 = count down.
- ld  input  1  synchronous parallel load.
- d  input  4*DIGITS  load value, packed BCD; digit k is d[4k+3:4k].
- q  output  4*DIGITS  count value, packed BCD.
- co  output  1  terminal-count carry-out, combinational.

Behaviour:
- Reset: mr_n=0 forces q=0 immediately, regardless of clk; co=0 while reset is held. Release is synchronous to the next clk edge; the first count happens on the first rising edge after mr_n=1.
- Priority at each rising edge: ld, then count, then hold.
- Load (ld=1):
  - q<=d on the next edge, regardless of en/ci.
  - Any digit >9 loads as 0; the top digit >=TOP_MOD loads as 0.
  - co=0 while ld=1.
- Count (ld=0, en=1, ci=1), up=1:
  - Digit 0 increments.
  - Digit k increments only when digits 0..k-1 are all at max (9).
  - A digit at max wraps to 0. The top digit's max is TOP_MOD-1.
- Count, up=0:
  - Digit 0 decrements.
  - Digit k decrements only when digits 0..k-1 are all 0.
  - 0 wraps to max (9, or TOP_MOD-1 for the top digit).
- Hold: en=0 or ci=0 -> q unchanged. up may change on any cycle; the new direction applies from the next edge.
- Full wrap: up at all-max -> all 0; down at all-0 -> all-max (e.g. 59 -> 00 and 00 -> 59 for DIGITS=2, TOP_MOD=6).
- co = en & ci & ~ld & terminal, where terminal means:
  - up=1: every digit at max;
  - down=0: every digit is 0.
  - co is high for exactly the one cycle before the wrap.
- Cascading: the upper instance's ci = the lower instance's co, with en shared. The upper instance steps on the same edge the lower one wraps.
- Latency: one clk from ld/en to q. co reacts combinationally to en, ci, up and ld.
- q is always legal BCD; no out-of-range state is reachable.

Optional Feature:
- Macro: BCD_UPDOWN_COUNTER_SAT_EN
- Defined: saturating mode.
  - Counting up at all-max holds all-max; counting down at all-0 holds all-0. No wrap.
  - co still asserts under the same terminal condition and stays high while saturated and enabled.
- Undefined: wrap-around behaviour as specified above.

Test Plan (DIGITS=2, TOP_MOD=6 unless stated):
- Reset mid-count:
  - Count up to 37, pulse mr_n=0 between edges -> q=00 immediately, co=0.
  - Release mr_n, en=1 -> q=01 after the first edge.
- Up wrap:
  - From 00, en=ci=up=1 for 60 edges -> q sequences 00..59 then 00.
  - co=1 only during the cycle where q=59.
- Down and direction change:
  - Load 10, up=0, one edge -> 09; two more edges -> 07.
  - Set up=1, one edge -> 08. From 00 with up=0, one edge -> 59, with co=1 in the 00 cycle.
- Load priority and clamping:
  - ld=1, en=1, d=0x47 -> q=47, co=0.
  - d=0x7A -> q=00; the top digit 7>=6 and the low digit A>9 both clamp to 0.
- Enable gating:
  - en=1, ci=0 for 5 edges -> q unchanged, co=0.
  - Two instances chained (lower DIGITS=1, TOP_MOD=10) -> upper steps exactly when lower goes 9 -> 0.
- Saturation (BCD_UPDOWN_COUNTER_SAT_EN defined):
  - At 59, up, 3 edges -> q stays 59, co=1 throughout.
  - At 00, down, 3 edges -> q stays 00.
